// File: rtl/raggedstone_spinn_aer_if_pkg.sv
// Shared LED mode encoding for the SpiNNaker AER interface status LEDs.
// Pure definitions: no logic, no latency, no flow control.
package raggedstone_spinn_aer_if_pkg;

  localparam int MODE_W    = 3;
  localparam int PRESC_W   = 20;
  localparam int PHASE_W   = 4;
  localparam int STRETCH_W = 4;

  typedef enum logic [MODE_W-1:0] {
    MODE_OFF  = 3'd0,
    MODE_ON   = 3'd1,
    MODE_SLOW = 3'd2,
    MODE_FAST = 3'd3,
    MODE_ACT  = 3'd4
  } led_mode_e;

endpackage

// File: rtl/raggedstone_spinn_aer_if_led_channel.sv
// One LED channel: activity stretch counter, mode mux and registered pin.
// Latency: 1 clk from mode/phase/stretch state to pin; no backpressure.
module raggedstone_spinn_aer_if_led_channel
  import raggedstone_spinn_aer_if_pkg::*;
#(
  parameter int unsigned STRETCH_TICKS  = 4,
  parameter bit          LED_ACTIVE_LOW = 1'b1
) (
  input  logic              rst,
  input  logic              clk,
  input  logic [MODE_W-1:0] mode,
  input  logic              activity,
  input  logic              tick,
  input  logic              phase_fast,
  input  logic              phase_slow,
  output logic              led_out
);

  localparam logic [STRETCH_W-1:0] STRETCH_LD = STRETCH_TICKS[STRETCH_W-1:0];

  logic [STRETCH_W-1:0] stretch_q, stretch_d;
  logic                 led_q, led_d;
  logic                 lit;

  always_comb begin
    stretch_d = stretch_q;
    // A fresh event always restarts the full stretch, even mid-decrement.
    if (activity) begin
      stretch_d = STRETCH_LD;
    end else if (tick && (stretch_q != '0)) begin
      stretch_d = stretch_q - 1'b1;
    end

    lit = 1'b0;
    case (mode)
      MODE_ON:   lit = 1'b1;
      MODE_SLOW: lit = phase_slow;
      MODE_FAST: lit = phase_fast;
      MODE_ACT:  lit = (stretch_q != '0);
      default:   lit = 1'b0;
    endcase

    led_d = lit ^ LED_ACTIVE_LOW;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stretch_q <= '0;
      led_q     <= LED_ACTIVE_LOW;
    end else begin
      stretch_q <= stretch_d;
      led_q     <= led_d;
    end
  end

  assign led_out = led_q;

endmodule

// File: rtl/raggedstone_spinn_aer_if_led_driver.sv
// Status LED driver: shared prescaler/blink phase feeding NUM_LEDS channels.
// Latency: 1 clk from inputs to led_out; tick is a registered 1-cycle strobe.
module raggedstone_spinn_aer_if_led_driver
  import raggedstone_spinn_aer_if_pkg::*;
#(
  parameter int unsigned         NUM_LEDS       = 4,
  parameter logic [PRESC_W-1:0]  PRESCALE       = 20'hfffff,
  parameter int unsigned         STRETCH_TICKS  = 4,
  parameter bit                  LED_ACTIVE_LOW = 1'b1
) (
  input  logic                         rst,
  input  logic                         clk,
  input  logic [MODE_W*NUM_LEDS-1:0]   led_mode,
  input  logic [NUM_LEDS-1:0]          activity,
  output logic [NUM_LEDS-1:0]          led_out,
  output logic                         tick
);

  logic [PRESC_W-1:0] presc_q, presc_d;
  logic [PHASE_W-1:0] phase_q, phase_d;
  logic               tick_q, tick_d;

  always_comb begin
    presc_d = (presc_q == '0) ? PRESCALE : presc_q - 1'b1;
    tick_d  = (presc_q == '0);
    // Phase wraps naturally 15->0; mode changes never touch it.
    phase_d = tick_q ? phase_q + 1'b1 : phase_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_q <= PRESCALE;
      phase_q <= '0;
      tick_q  <= 1'b0;
    end else begin
      presc_q <= presc_d;
      phase_q <= phase_d;
      tick_q  <= tick_d;
    end
  end

  assign tick = tick_q;

  for (genvar i = 0; i < NUM_LEDS; i++) begin : g_chan
    raggedstone_spinn_aer_if_led_channel #(
      .STRETCH_TICKS  (STRETCH_TICKS),
      .LED_ACTIVE_LOW (LED_ACTIVE_LOW)
    ) u_chan (
      .rst        (rst),
      .clk        (clk),
      .mode       (led_mode[MODE_W*i +: MODE_W]),
      .activity   (activity[i]),
      .tick       (tick_q),
      .phase_fast (phase_q[0]),
      .phase_slow (phase_q[2]),
      .led_out    (led_out[i])
    );
  end

endmodule

// File: tb/tb_raggedstone_spinn_aer_if_led_driver.sv
// Directed bench for the LED driver with PRESCALE=3, STRETCH_TICKS=2, active-low pins.
// Expected values derive from the edge count k since the last reset release.
module tb_raggedstone_spinn_aer_if_led_driver;

  logic        rst;
  logic        clk;
  logic [11:0] led_mode;
  logic [3:0]  activity;
  logic [3:0]  led_out;
  logic        tick;

  int n_asserts = 0;
  int n_fails   = 0;
  int k         = 0;

  raggedstone_spinn_aer_if_led_driver #(
    .NUM_LEDS       (4),
    .PRESCALE       (20'd3),
    .STRETCH_TICKS  (2),
    .LED_ACTIVE_LOW (1'b1)
  ) dut (
    .rst      (rst),
    .clk      (clk),
    .led_mode (led_mode),
    .activity (activity),
    .led_out  (led_out),
    .tick     (tick)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s (k=%0d): observed %0h expected %0h", tag, k, obs, exp);
    end
  endtask

  // Advance one posedge and sample on the following negedge.
  task automatic cyc();
    @(negedge clk);
    k++;
  endtask

  initial begin
    rst      = 1'b0;
    led_mode = '0;
    activity = '0;
    #2 rst = 1'b1;
    #2;
    chk("reset_led", {28'd0, led_out}, 32'hF);
    chk("reset_tick", {31'd0, tick}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    k   = 0;

    // All OFF: pins high, tick every 4th cycle.
    for (int i = 1; i <= 8; i++) begin
      cyc();
      chk("tick_period", {31'd0, tick}, {31'd0, (k % 4 == 0)});
      chk("all_off", {28'd0, led_out}, 32'hF);
    end

    // LED0 FAST, LED1 SLOW; pin reflects phase after the previous edge.
    led_mode = {3'd0, 3'd0, 3'd2, 3'd3};
    for (int i = 9; i <= 40; i++) begin
      cyc();
      chk("fast_blink", {31'd0, led_out[0]}, {31'd0, !(((k - 2) / 4) % 2 == 1)});
      chk("slow_blink", {31'd0, led_out[1]}, {31'd0, !(((k - 2) / 16) % 2 == 1)});
      chk("idle_upper", {30'd0, led_out[3:2]}, 32'd3);
    end

    // Single activity pulse on LED2 in ACT mode.
    led_mode = {3'd0, 3'd4, 3'd0, 3'd0};
    cyc();                         // k=41
    activity = 4'b0100;
    cyc();                         // k=42: loaded, pin not yet lit
    activity = 4'b0000;
    chk("act_pre", {31'd0, led_out[2]}, 32'd1);
    for (int i = 43; i <= 52; i++) begin
      cyc();
      chk("act_pulse", {31'd0, led_out[2]}, {31'd0, (k >= 50)});
    end

    // Activity held across several ticks, dropped at k=64.
    activity = 4'b0100;
    for (int i = 53; i <= 64; i++) begin
      cyc();
      chk("act_hold", {31'd0, led_out[2]}, {31'd0, (k == 53)});
    end
    activity = 4'b0000;
    for (int i = 65; i <= 72; i++) begin
      cyc();
      chk("act_release", {31'd0, led_out[2]}, {31'd0, (k >= 70)});
    end

    // Reserved modes on LED3 stay dark despite activity.
    for (int m = 5; m <= 7; m++) begin
      led_mode = {m[2:0], 3'd4, 3'd0, 3'd0};
      activity = 4'b1000;
      cyc();
      activity = 4'b0000;
      chk("reserved_mode", {31'd0, led_out[3]}, 32'd1);
      for (int j = 0; j < 3; j++) begin
        cyc();
        chk("reserved_mode", {31'd0, led_out[3]}, 32'd1);
      end
    end
    led_mode = {3'd1, 3'd4, 3'd0, 3'd0};
    cyc();
    chk("mode_on", {31'd0, led_out[3]}, 32'd0);

    // Reset in the middle of a stretch on LED2.
    led_mode = {3'd0, 3'd4, 3'd0, 3'd0};
    activity = 4'b0100;
    cyc();
    activity = 4'b0000;
    cyc();
    chk("stretch_before_rst", {31'd0, led_out[2]}, 32'd0);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_led", {28'd0, led_out}, 32'hF);
    chk("async_rst_tick", {31'd0, tick}, 32'd0);
    cyc();
    chk("rst_held", {28'd0, led_out}, 32'hF);
    rst = 1'b0;
    k   = 0;
    for (int i = 1; i <= 10; i++) begin
      cyc();
      chk("post_rst_tick", {31'd0, tick}, {31'd0, (k % 4 == 0)});
      chk("post_rst_dark", {28'd0, led_out}, 32'hF);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
    $finish;
  end

endmodule
